// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and iteration count for the DIV/DIVU sequencer
package div_ctrl_pkg;
   localparam int DIV_ITER = 32;
   typedef enum logic [1:0] {
      DIV_IDLE   = 2'd0,
      DIV_BYZERO = 2'd1,
      DIV_ON     = 2'd2,
      DIV_END    = 2'd3
   } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration on the packed {remainder, quotient} pair
module div_step
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_ITER
) (
   input  logic [2*WIDTH-1:0] i_rq,
   input  logic [WIDTH-1:0]   i_divisor,
   output logic [2*WIDTH-1:0] o_rq
);
   logic [WIDTH:0] w_trial;
   // the remainder top bit shifted out must take part in the trial subtract
   assign w_trial = i_rq[2*WIDTH-1:WIDTH-1] - {1'b0, i_divisor};
   assign o_rq = w_trial[WIDTH] ? {i_rq[2*WIDTH-2:0], 1'b0}
                                : {w_trial[WIDTH-1:0], i_rq[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer; stalls EX while a restoring divider runs
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_ITER
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               div_start,
   input  logic               div_signed,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall
);
   localparam int CW = $clog2(WIDTH);
   div_state_e         r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_divisor;
   logic [2*WIDTH-1:0] r_rq, r_result, w_rq;
   logic               r_sign_q, r_sign_r;
   logic               w_last;
   logic [WIDTH-1:0]   w_mag1, w_mag2, w_rem, w_quo;
   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rq      (r_rq),
      .i_divisor (r_divisor),
      .o_rq      (w_rq)
   );
   assign w_last = r_cnt == CW'(WIDTH - 1);
   assign w_mag1 = (div_signed & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
   assign w_mag2 = (div_signed & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
   assign w_rem  = r_sign_r ? -w_rq[2*WIDTH-1:WIDTH] : w_rq[2*WIDTH-1:WIDTH];
   assign w_quo  = r_sign_q ? -w_rq[WIDTH-1:0] : w_rq[WIDTH-1:0];
   assign result = r_result;
   always_comb begin
      w_next = r_state;
      case (r_state)
         DIV_IDLE:   w_next = !div_start ? DIV_IDLE : (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
         DIV_BYZERO: w_next = DIV_END;
         DIV_ON:     w_next = w_last ? DIV_END : DIV_ON;
         default:    w_next = DIV_IDLE;
      endcase
      if (annul) w_next = DIV_IDLE;
      ready = (r_state == DIV_END) & ~annul;
      stall = resetn & div_start & ~annul & (r_state != DIV_END);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= DIV_IDLE;
      else         r_state <= w_next;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt     <= '0;
         r_divisor <= '0;
         r_rq      <= '0;
         r_result  <= '0;
         r_sign_q  <= 1'b0;
         r_sign_r  <= 1'b0;
      end else if (r_state == DIV_IDLE && div_start && !annul) begin
         r_rq      <= {{WIDTH{1'b0}}, w_mag1};
         r_divisor <= w_mag2;
         r_sign_q  <= div_signed & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
         r_sign_r  <= div_signed & opdata1[WIDTH-1];
         r_cnt     <= '0;
      end else if (r_state == DIV_ON && !annul) begin
         r_rq  <= w_rq;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) r_result <= {w_rem, w_quo};
      end else if (r_state == DIV_BYZERO && !annul) begin
         r_result <= '0;
      end
   end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: cycle-accurate checks of the divide sequencer against an arithmetic reference
module tb_div_ctrl;
   logic        clk = 1'b0;
   logic        resetn, div_start, div_signed, annul;
   logic [31:0] opdata1, opdata2;
   logic [63:0] result;
   logic        ready, stall;
   int          vectors = 0;
   int          miscompares = 0;

   div_ctrl #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_start  (div_start),
      .div_signed (div_signed),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   // reference: plain 64-bit integer division, truncating toward zero
   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return 64'd0;
      x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      div_start = 1'b0;
      annul     = 1'b0;
      tick();
   endtask

   // starts a divide in the current cycle, checks every cycle through END, leaves div_start high
   task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
      int lat;
      lat = (b == 32'd0) ? 2 : 33;
      div_start = 1'b1; div_signed = sgn; opdata1 = a; opdata2 = b; annul = 1'b0;
      for (int c = 0; c <= lat; c++) begin
         #1;
         vectors++;
         if (stall !== (c < lat)) begin
            miscompares++;
            $display("FAIL %s stall cyc %0d: got %b exp %b", name, c, stall, c < lat);
         end
         vectors++;
         if (ready !== (c == lat)) begin
            miscompares++;
            $display("FAIL %s ready cyc %0d: got %b exp %b", name, c, ready, c == lat);
         end
         if (c == lat) begin
            vectors++;
            if (result !== exp) begin
               miscompares++;
               $display("FAIL %s result %0d/%0d sgn=%0d: got %h exp %h", name, a, b, sgn, result, exp);
            end
         end
         tick();
         if (c == 0) begin
            opdata1 = $urandom; opdata2 = $urandom; div_signed = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; div_start = 1'b1; div_signed = 1'b0; annul = 1'b0;
      opdata1 = 32'd100; opdata2 = 32'd7;
      #1;
      vectors++;
      if ({result, ready, stall} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset outputs: got %h/%b/%b exp 0/0/0", result, ready, stall);
      end
      tick(); tick();
      resetn = 1'b1;
      idle();
   endtask

   task automatic test_unsigned();
      run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, "divu_100_7");
      idle();
   endtask

   task automatic test_signed();
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
      idle();
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, "div_7_m2");
      idle();
   endtask

   task automatic test_zero();
      run_div(1'b1, 32'd5, 32'd0, 64'd0, "div_by_zero");
      idle();
   endtask

   task automatic test_annul();
      bit seen;
      div_start = 1'b1; div_signed = 1'b0; opdata1 = 32'hFFFFFFFF; opdata2 = 32'd3; annul = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      annul = 1'b1;
      #1;
      vectors++;
      if ({stall, ready} !== 2'b00) begin
         miscompares++;
         $display("FAIL annul outputs: got stall=%b ready=%b exp 0/0", stall, ready);
      end
      tick();
      annul = 1'b0; div_start = 1'b0; seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (ready) seen = 1'b1;
         tick();
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL annul ready pulse: got %b exp 0", seen);
      end
      run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "after_annul");
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      a = $urandom; b = $urandom_range(1, 1000);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, "overflow");
      run_div(1'b0, a, b, model(1'b0, a, b), "b2b_second");
      idle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b;
      div_start = 1'b1; div_signed = 1'b0; opdata1 = 32'd1234567; opdata2 = 32'd89; annul = 1'b0;
      for (int c = 0; c < 15; c++) tick();
      resetn = 1'b0;
      #1;
      vectors++;
      if ({result, ready, stall} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_mid outputs: got %h/%b/%b exp 0/0/0", result, ready, stall);
      end
      tick();
      resetn = 1'b1;
      idle();
      a = $urandom; b = $urandom_range(1, 50);
      run_div(1'b1, a, b, model(1'b1, a, b), "after_reset");
      idle();
   endtask

   task automatic test_random();
      bit          sgn;
      logic [31:0] a, b;
      for (int i = 0; i < 16; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         run_div(sgn, a, b, model(sgn, a, b), "random");
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_zero();
      test_annul();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
